mult_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one shift-add sequential multiplier

---
 rtl/ed25519_pkg.sv | 21 ++
 rtl/mult_arbiter_if.sv | 30 +++
 rtl/mult_arbiter_core.sv | 71 +++++++
 rtl/mult_arbiter.sv | 148 ++++++++++++++
 tb/tb_mult_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ed25519_pkg.sv
// Shared curve constants and the arbiter FSM state type.
//   B, B2 : field operand width and full product width
//   Q     : field prime 2^255 - 19
//   L     : group order 2^252 + 27742317777372353535851937790883648493
package ed25519_pkg;

  localparam int B  = 256;
  localparam int B2 = 512;

  localparam logic [B-1:0] Q =
    256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [B-1:0] L =
    256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bundle of the shared multiplier arbiter.
//   req       : per-requester request level
//   a_in/b_in : operands, slice i = [i*W +: W]
//   gnt       : one-hot 1-cycle pulse, operands of requester i captured
//   rsp_valid : one-hot 1-cycle pulse, product belongs to requester i
//   product   : 2W-bit unreduced product, held until the next rsp_valid
//   busy      : high from the grant edge through the rsp_valid edge
// master = requesters, slave = arbiter.
interface mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 256
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    product;
  logic              busy;

  modport master (
    output req, a_in, b_in,
    input  gnt, rsp_valid, product, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, rsp_valid, product, busy
  );
endinterface

// File: rtl/mult_arbiter_core.sv
// Sequential right-shift/add multiplier, one partial product per clock.
//   clk, rst : clock, async active-high reset
//   start    : 1-cycle pulse, loads a and b
//   a, b     : W-bit operands
//   done     : 1-cycle pulse exactly W edges after the start edge
//   p        : exact 2W-bit product, held until the next start
module mult_core_seq #(
  parameter int W = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   a_q, a_d;
  logic [2*W-1:0] p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           done_q, done_d;
  logic [W:0]     sum;

  // Upper half accumulates; the multiplier sits in the lower half and is
  // consumed one bit per cycle as the whole register shifts right.
  always_comb begin
    a_d    = a_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    sum    = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    if (start) begin
      a_d   = a;
      p_d   = {{W{1'b0}}, b};
      cnt_d = CW'(W);
      run_d = 1'b1;
    end else if (run_q) begin
      p_d   = {sum, p_q[W-1:1]};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = p_q;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ requesters.
//   clk, rst : clock, async active-high reset
//   bus      : mult_arbiter_if slave (req/a_in/b_in in; gnt/rsp_valid/product/busy out)
// All outputs are registered; req only reaches gnt through the state register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for any req; picks next requester after last grant
// ST_LOAD | operands captured, start pulse to the multiplier core
// ST_RUN  | multiplier iterating; on core done, return product to owner
module mult_arbiter
  import ed25519_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = B
) (
  input  logic           clk,
  input  logic           rst,
  mult_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_q, rsp_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2*W-1:0]  product_q, product_d;
  logic            busy_q, busy_d;

  logic            core_start;
  logic            core_done;
  logic [2*W-1:0]  core_p;
  logic [IW-1:0]   pick_idx;

  // Walk the request vector starting just after the last winner, wrapping
  // at NREQ; the first set bit wins.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] res;
    logic [IW-1:0] ix;
    logic          found;
    int            pos;
    res   = last;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(last) + 1 + k;
      if (pos >= NREQ) pos = pos - NREQ;
      ix = IW'(pos);
      if (!found && r[ix]) begin
        res   = ix;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign pick_idx = rr_pick(bus.req, last_q);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    rsp_d      = '0;
    a_d        = a_q;
    b_d        = b_q;
    product_d  = product_q;
    busy_d     = busy_q;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
              a_d = bus.a_in[i*W +: W];
              b_d = bus.b_in[i*W +: W];
            end
          end
          owner_d = pick_idx;
          last_d  = pick_idx;
          gnt_d   = ONE << pick_idx;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_start = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (core_done) begin
          product_d = core_p;
          rsp_d     = ONE << owner_q;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= IW'(NREQ - 1);
      owner_q   <= '0;
      gnt_q     <= '0;
      rsp_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      rsp_q     <= rsp_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      busy_q    <= busy_d;
    end
  end

  // Operands come from the captured registers so requester inputs may
  // change freely once gnt has been seen.
  mult_core_seq #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .a     (a_q),
    .b     (b_q),
    .done  (core_done),
    .p     (core_p)
  );

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
  import ed25519_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 256;
  localparam int PW   = 2 * W;
  localparam int LAT  = W + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int exp_last;
  logic [W-1:0] cap_a, cap_b;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] x, y;
    x = PW'(a);
    y = PW'(b);
    return x * y;
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0 && i < NREQ) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
  endtask

  // Waits for a grant; checks it against the round-robin rule applied to
  // the request vector the bench is holding.
  task automatic wait_gnt(output int idx, output int cyc);
    int e;
    cyc = 0;
    idx = -1;
    while (bus.gnt == '0 && cyc < 4 * W) begin
      @(negedge clk);
      cyc++;
    end
    check("gnt_seen", PW'(bus.gnt != '0), PW'(1));
    if (bus.gnt != '0) begin
      e = ref_pick(bus.req, exp_last);
      check("gnt_idx", PW'(bus.gnt), PW'(oh(e)));
      check("busy_at_gnt", PW'(bus.busy), PW'(1));
      if (e >= 0) begin
        cap_a    = bus.a_in[e*W +: W];
        cap_b    = bus.b_in[e*W +: W];
        exp_last = e;
      end
      idx = e;
    end
  endtask

  // Waits for the response, cyc0 negedges already spent since the grant.
  task automatic wait_rsp(input int idx, input int cyc0);
    int cyc;
    cyc = cyc0;
    while (bus.rsp_valid == '0 && cyc < 4 * W) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_latency", PW'(cyc), PW'(LAT));
    check("rsp_idx", PW'(bus.rsp_valid), PW'(oh(idx)));
    check("product", bus.product, ref_mul(cap_a, cap_b));
    check("busy_clear", PW'(bus.busy), PW'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_last = NREQ - 1;
  endtask

  initial begin
    int idx, cyc, c, seen, iter;
    logic [PW-1:0] k_ones;
    rst       = 1'b1;
    bus.req   = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    exp_last  = NREQ - 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_gnt", PW'(bus.gnt), PW'(0));
    check("rst_rsp", PW'(bus.rsp_valid), PW'(0));
    check("rst_product", bus.product, PW'(0));
    check("rst_busy", PW'(bus.busy), PW'(0));

    // 1: single requester, 3*5
    set_ops(0, W'(3), W'(5));
    bus.req = 4'b0001;
    wait_gnt(idx, cyc);
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("gnt_one_cycle", PW'(bus.gnt), PW'(0));
    repeat (9) @(negedge clk);
    check("busy_in_run", PW'(bus.busy), PW'(1));
    wait_rsp(idx, 10);
    check("product_15", bus.product, PW'(15));

    // 2: all held high -> 0,1,2,3,0 with W+3 spacing
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, rnd_w(), rnd_w());
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(idx, cyc);
      check("rr_order", PW'(bus.gnt), PW'(oh(i % NREQ)));
      if (i > 0) check("gnt_spacing", PW'(cyc + LAT), PW'(W + 3));
      wait_rsp(idx, 0);
    end
    bus.req = '0;

    // 3: boundary operands
    set_ops(1, Q, W'(2));
    bus.req = 4'b0010;
    wait_gnt(idx, cyc);
    bus.req[1] = 1'b0;
    wait_rsp(idx, 0);
    check("product_2q", bus.product, PW'(Q) << 1);
    set_ops(2, {W{1'b1}}, {W{1'b1}});
    bus.req = 4'b0100;
    wait_gnt(idx, cyc);
    bus.req[2] = 1'b0;
    wait_rsp(idx, 0);
    k_ones = {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1};
    check("product_max", bus.product, k_ones);

    // 4: req3 arrives during RUN of req0
    set_ops(0, rnd_w(), rnd_w());
    set_ops(3, rnd_w(), rnd_w());
    bus.req = 4'b0001;
    wait_gnt(idx, cyc);
    bus.req[0] = 1'b0;
    repeat (50) @(negedge clk);
    bus.req[3] = 1'b1;
    wait_rsp(idx, 50);
    wait_gnt(idx, cyc);
    check("late_req_next_edge", PW'(cyc), PW'(1));
    bus.req[3] = 1'b0;
    wait_rsp(idx, 0);

    // 5: reset in the middle of RUN
    set_ops(0, rnd_w(), rnd_w());
    bus.req = 4'b0001;
    wait_gnt(idx, cyc);
    bus.req[0] = 1'b0;
    repeat (101) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt", PW'(bus.gnt), PW'(0));
    check("midrst_rsp", PW'(bus.rsp_valid), PW'(0));
    check("midrst_product", bus.product, PW'(0));
    check("midrst_busy", PW'(bus.busy), PW'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_last = NREQ - 1;
    seen = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0 || bus.gnt != '0) seen++;
    end
    check("no_rsp_after_rst", PW'(seen), PW'(0));
    for (int i = 1; i < 3; i++) set_ops(i, rnd_w(), rnd_w());
    bus.req = 4'b0110;
    wait_gnt(idx, cyc);
    check("post_rst_first", PW'(bus.gnt), PW'(4'b0010));
    bus.req[1] = 1'b0;
    wait_rsp(idx, 0);
    wait_gnt(idx, cyc);
    bus.req[2] = 1'b0;
    wait_rsp(idx, 0);

    // 6: req2 pulsed and dropped while busy; operands churn during RUN
    set_ops(0, rnd_w(), rnd_w());
    bus.req = 4'b0001;
    wait_gnt(idx, cyc);
    bus.req[0] = 1'b0;
    c = 0;
    repeat (20) begin @(negedge clk); c++; end
    bus.req[2] = 1'b1;
    set_ops(2, rnd_w(), rnd_w());
    repeat (3) begin @(negedge clk); c++; end
    bus.req[2] = 1'b0;
    set_ops(0, rnd_w(), rnd_w());
    set_ops(2, rnd_w(), rnd_w());
    wait_rsp(idx, c);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) seen++;
    end
    check("dropped_req_no_gnt", PW'(seen), PW'(0));

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, rnd_w(), rnd_w());
      bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      iter = 0;
      while (bus.req != '0 && iter < 12) begin
        wait_gnt(idx, cyc);
        if (idx >= 0) bus.req[idx] = 1'b0;
        c = $urandom_range(1, W - 1);
        repeat (c) @(negedge clk);
        if (iter < 3) begin
          int n;
          n = $urandom_range(0, NREQ - 1);
          if (!bus.req[n]) set_ops(n, rnd_w(), rnd_w());
          bus.req[n] = 1'b1;
        end
        wait_rsp(idx, c);
        iter++;
      end
      bus.req = '0;
      repeat (4) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
